// File: rtl/dac_load_sequencer_if.sv
// Host-side command/response handshake between the host interface logic and
// the DAC load sequencer.
interface dac_load_sequencer_if #(
    parameter int CODE_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [CODE_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [CODE_W-1:0] rsp_count;
    logic              done;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_count, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_count, done
    );
endinterface

// File: rtl/dac_load_sequencer.sv
// Turns host commands into cycle-exact datum/shift/transfer/dir sequences for
// the current-steering DAC cell array and its daisychain/state register pair.
module dac_load_sequencer #(
    parameter int N_CELLS = 128,
    parameter int CODE_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    dac_load_sequencer_if.slave   host,
    input  logic                  chain_msb_i,
    output logic                  datum_o,
    output logic                  shift_o,
    output logic                  transfer_o,
    output logic                  dir_o,
    output logic                  stateen_o
);

    typedef enum logic [2:0] {
        IDLE,
        WSHIFT,
        WXFER,
        RXFER,
        RSHIFT,
        RSP
    } state_e;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_READ   = 2'b01,
        OP_SET_EN = 2'b10,
        OP_NOP    = 2'b11
    } op_e;

    localparam logic [CODE_W-1:0] NC   = CODE_W'(N_CELLS);
    localparam logic [CODE_W-1:0] LAST = CODE_W'(N_CELLS - 1);

    state_e            state_q, state_d;
    logic [CODE_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CODE_W-1:0] thresh_q, thresh_d;
    logic [CODE_W-1:0] ones_q, ones_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              done_q, done_d;
    logic              datum_q, datum_d;
    logic              shift_q, shift_d;
    logic              transfer_q, transfer_d;
    logic              dir_q, dir_d;
    logic              stateen_q, stateen_d;

    logic              accept;
    logic [CODE_W-1:0] clamp_code;
    logic [CODE_W-1:0] thresh_new;
    logic [CODE_W-1:0] cnt_inc;

    assign accept     = host.cmd_valid && cmd_ready_q;
    assign clamp_code = (host.cmd_data > NC) ? NC : host.cmd_data;
    // Shift index k carries a one when k >= N_CELLS - code, so the last
    // `code` bits shifted in land at chain[code-1:0].
    assign thresh_new = NC - clamp_code;
    assign cnt_inc    = bit_cnt_q + CODE_W'(1);

    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned and a latch is never inferred.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        thresh_d    = thresh_q;
        ones_d      = ones_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        stateen_d   = stateen_q;
        done_d      = 1'b0;
        datum_d     = 1'b0;
        shift_d     = 1'b0;
        transfer_d  = 1'b0;
        dir_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (accept) begin
                    unique case (op_e'(host.cmd_op))
                        OP_WRITE: begin
                            state_d     = WSHIFT;
                            cmd_ready_d = 1'b0;
                            bit_cnt_d   = '0;
                            thresh_d    = thresh_new;
                            shift_d     = 1'b1;
                            datum_d     = (thresh_new == '0);
                        end
                        OP_READ: begin
                            state_d     = RXFER;
                            cmd_ready_d = 1'b0;
                            ones_d      = '0;
                            transfer_d  = 1'b1;
                        end
                        OP_SET_EN: begin
                            stateen_d = host.cmd_data[0];
                            done_d    = 1'b1;
                        end
                        OP_NOP: begin
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            WSHIFT: begin
                if (bit_cnt_q == LAST) begin
                    state_d    = WXFER;
                    transfer_d = 1'b1;
                    dir_d      = 1'b1;
                end else begin
                    bit_cnt_d = cnt_inc;
                    shift_d   = 1'b1;
                    datum_d   = (cnt_inc >= thresh_q);
                end
            end
            WXFER: begin
                state_d     = IDLE;
                done_d      = 1'b1;
                cmd_ready_d = 1'b1;
            end
            RXFER: begin
                state_d   = RSHIFT;
                bit_cnt_d = '0;
                shift_d   = 1'b1;
            end
            RSHIFT: begin
                // chain_msb is the bit about to leave the chain on this edge.
                ones_d = ones_q + CODE_W'(chain_msb_i);
                if (bit_cnt_q == LAST) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                end else begin
                    bit_cnt_d = cnt_inc;
                    shift_d   = 1'b1;
                end
            end
            RSP: begin
                if (host.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    done_d      = 1'b1;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            thresh_q    <= '0;
            ones_q      <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            done_q      <= 1'b0;
            datum_q     <= 1'b0;
            shift_q     <= 1'b0;
            transfer_q  <= 1'b0;
            dir_q       <= 1'b0;
            stateen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            thresh_q    <= thresh_d;
            ones_q      <= ones_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            done_q      <= done_d;
            datum_q     <= datum_d;
            shift_q     <= shift_d;
            transfer_q  <= transfer_d;
            dir_q       <= dir_d;
            stateen_q   <= stateen_d;
        end
    end

    assign host.cmd_ready = cmd_ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_count = ones_q;
    assign host.done      = done_q;
    assign datum_o        = datum_q;
    assign shift_o        = shift_q;
    assign transfer_o     = transfer_q;
    assign dir_o          = dir_q;
    assign stateen_o      = stateen_q;

endmodule

// File: tb/tb_dac_load_sequencer.sv
// Directed bench for dac_load_sequencer with a behavioural model of the
// daisychain/state register pair driven by the sequencer's control pins.
module tb_dac_load_sequencer;

    localparam int N = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chain_msb;
    logic datum_o, shift_o, transfer_o, dir_o, stateen_o;

    int total = 0;
    int bad   = 0;
    logic excl_err = 1'b0;

    dac_load_sequencer_if #(.CODE_W(8)) hif ();

    dac_load_sequencer #(.N_CELLS(N), .CODE_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (hif),
        .chain_msb_i (chain_msb),
        .datum_o     (datum_o),
        .shift_o     (shift_o),
        .transfer_o  (transfer_o),
        .dir_o       (dir_o),
        .stateen_o   (stateen_o)
    );

    always #5 clk = ~clk;

    // Array model: chain shifts toward the MSB, datum enters at bit 0.
    logic [N-1:0] chain_m = '0;
    logic [N-1:0] state_m = '0;

    always @(posedge clk) begin
        if (shift_o) chain_m <= {chain_m[N-2:0], datum_o};
        else if (transfer_o) begin
            if (dir_o) state_m <= chain_m;
            else       chain_m <= state_m;
        end
    end

    assign chain_msb = chain_m[N-1];

    always @(negedge clk) begin
        if (!rst && ((shift_o && transfer_o) || (dir_o && !transfer_o)))
            excl_err = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offers a command at a negedge; returns at the negedge of cycle 1.
    task automatic issue(input logic [1:0] op, input logic [7:0] data);
        int guard = 0;
        while (hif.cmd_ready !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 500) begin
            bad++;
            $display("FAIL issue_ready_timeout: cmd_ready=%b after %0d cycles, want 1", hif.cmd_ready, guard);
        end
        hif.cmd_valid = 1'b1;
        hif.cmd_op    = op;
        hif.cmd_data  = data;
        @(negedge clk);
        hif.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        hif.cmd_valid = 1'b0;
        hif.cmd_op    = 2'b11;
        hif.cmd_data  = '0;
        hif.rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({hif.cmd_ready, hif.rsp_valid, hif.rsp_count, hif.done, datum_o,
             shift_o, transfer_o, dir_o, stateen_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: rdy=%b rv=%b cnt=%0d done=%b datum=%b shift=%b xfer=%b dir=%b en=%b, want all 0",
                     hif.cmd_ready, hif.rsp_valid, hif.rsp_count, hif.done, datum_o,
                     shift_o, transfer_o, dir_o, stateen_o);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (hif.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: cmd_ready=%b want 1", hif.cmd_ready);
        end
    endtask

    // Ends at the negedge of cycle N+2 (done cycle), ready for back-to-back.
    task automatic do_write(input string name, input int code, input logic [N-1:0] want);
        int n;
        int sh_bad = 0, dt_bad = 0, xf_bad = 0, dn_bad = 0;
        n = (code > N) ? N : code;
        issue(2'b00, 8'(code));
        for (int c = 1; c <= N + 2; c++) begin
            if (c > 1) @(negedge clk);
            if (shift_o !== (c <= N)) sh_bad++;
            if (c <= N && datum_o !== ((c - 1) >= (N - n))) dt_bad++;
            if (transfer_o !== (c == N + 1) || (c == N + 1 && dir_o !== 1'b1)) xf_bad++;
            if (hif.done !== (c == N + 2) || hif.cmd_ready !== (c == N + 2)) dn_bad++;
        end
        total++;
        if (sh_bad != 0) begin bad++; $display("FAIL %s_shift: bad_cycles=%0d want 0", name, sh_bad); end
        total++;
        if (dt_bad != 0) begin bad++; $display("FAIL %s_datum: bad_cycles=%0d want 0", name, dt_bad); end
        total++;
        if (xf_bad != 0) begin bad++; $display("FAIL %s_transfer: bad_cycles=%0d want 0", name, xf_bad); end
        total++;
        if (dn_bad != 0) begin bad++; $display("FAIL %s_done_ready: bad_cycles=%0d want 0", name, dn_bad); end
        total++;
        if (state_m !== want) begin
            bad++;
            $display("FAIL %s_state: got=%h want=%h", name, state_m, want);
        end
    endtask

    task automatic do_read(input string name, input int want_count, input int hold);
        int sh_bad = 0, xf_bad = 0, st_bad = 0, hd_bad = 0;
        hif.rsp_ready = (hold == 0);
        issue(2'b01, 8'hA5);
        for (int c = 1; c <= N + 2; c++) begin
            if (c > 1) @(negedge clk);
            if (shift_o !== (c >= 2 && c <= N + 1) || (shift_o && datum_o)) sh_bad++;
            if (transfer_o !== (c == 1) || (c == 1 && dir_o !== 1'b0)) xf_bad++;
            if (hif.done !== 1'b0 || hif.cmd_ready !== 1'b0 || hif.rsp_valid !== (c == N + 2)) st_bad++;
        end
        total++;
        if (sh_bad != 0) begin bad++; $display("FAIL %s_shift: bad_cycles=%0d want 0", name, sh_bad); end
        total++;
        if (xf_bad != 0) begin bad++; $display("FAIL %s_transfer: bad_cycles=%0d want 0", name, xf_bad); end
        total++;
        if (st_bad != 0) begin bad++; $display("FAIL %s_status: bad_cycles=%0d want 0", name, st_bad); end
        total++;
        if (hif.rsp_count !== 8'(want_count)) begin
            bad++;
            $display("FAIL %s_count: got=%0d want=%0d", name, hif.rsp_count, want_count);
        end
        if (hold > 0) begin
            hif.cmd_valid = 1'b1;
            hif.cmd_op    = 2'b11;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (hif.rsp_valid !== 1'b1 || hif.rsp_count !== 8'(want_count) ||
                    hif.cmd_ready !== 1'b0 || hif.done !== 1'b0) hd_bad++;
            end
            hif.cmd_valid = 1'b0;
            hif.rsp_ready = 1'b1;
            total++;
            if (hd_bad != 0) begin bad++; $display("FAIL %s_hold_stable: bad_cycles=%0d want 0", name, hd_bad); end
        end
        @(negedge clk);
        total++;
        if (hif.done !== 1'b1 || hif.rsp_valid !== 1'b0 || hif.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_handshake: done=%b rsp_valid=%b rdy=%b want 1 0 1", name, hif.done, hif.rsp_valid, hif.cmd_ready);
        end
        @(negedge clk);
        total++;
        if (hif.done !== 1'b0) begin
            bad++;
            $display("FAIL %s_done_once: done=%b want 0", name, hif.done);
        end
        total++;
        if (chain_m !== '0) begin
            bad++;
            $display("FAIL %s_chain_cleared: got=%h want 0", name, chain_m);
        end
    endtask

    task automatic test_set_en();
        issue(2'b10, 8'h01);
        total++;
        if (stateen_o !== 1'b1 || hif.done !== 1'b1 || shift_o !== 1'b0 || transfer_o !== 1'b0) begin
            bad++;
            $display("FAIL set_en_1: en=%b done=%b shift=%b xfer=%b want 1 1 0 0", stateen_o, hif.done, shift_o, transfer_o);
        end
        issue(2'b10, 8'hFE);
        total++;
        if (stateen_o !== 1'b0 || hif.done !== 1'b1 || shift_o !== 1'b0 || transfer_o !== 1'b0) begin
            bad++;
            $display("FAIL set_en_0: en=%b done=%b shift=%b xfer=%b want 0 1 0 0", stateen_o, hif.done, shift_o, transfer_o);
        end
        issue(2'b11, 8'hFF);
        total++;
        if (stateen_o !== 1'b0 || hif.done !== 1'b1 || hif.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL nop: en=%b done=%b rdy=%b want 0 1 1", stateen_o, hif.done, hif.cmd_ready);
        end
        @(negedge clk);
        total++;
        if (hif.done !== 1'b0) begin
            bad++;
            $display("FAIL nop_done_once: done=%b want 0", hif.done);
        end
    endtask

    task automatic test_reset_abort();
        logic [N-1:0] prior;
        int xf = 0, dn = 0;
        prior = state_m;
        issue(2'b10, 8'h01);
        issue(2'b00, 8'd64);
        for (int c = 2; c <= 60; c++) begin
            @(negedge clk);
            if (transfer_o) xf++;
            if (hif.done) dn++;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (stateen_o !== 1'b0 || shift_o !== 1'b0 || hif.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_reset_outputs: en=%b shift=%b rv=%b want 0 0 0", stateen_o, shift_o, hif.rsp_valid);
        end
        rst = 1'b0;
        repeat (N + 5) begin
            @(negedge clk);
            if (transfer_o) xf++;
            if (hif.done) dn++;
        end
        total++;
        if (xf != 0 || dn != 0) begin
            bad++;
            $display("FAIL abort_no_completion: transfers=%0d dones=%0d want 0 0", xf, dn);
        end
        total++;
        if (state_m !== prior) begin
            bad++;
            $display("FAIL abort_state_kept: got=%h want=%h", state_m, prior);
        end
        do_write("write64_after_abort", 64, {{(N-64){1'b0}}, {64{1'b1}}});
    endtask

    initial begin
        hif.cmd_valid = 1'b0;
        hif.cmd_op    = 2'b11;
        hif.cmd_data  = '0;
        hif.rsp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        do_write("write5", 5, 128'h1F);
        do_read("read5_back_to_back", 5, 0);
        do_write("write200", 200, {N{1'b1}});
        do_read("read128_hold", 128, 10);
        do_write("write0", 0, '0);
        do_read("read0", 0, 0);
        test_set_en();
        do_write("write5_prior", 5, 128'h1F);
        test_reset_abort();
        do_read("read64", 64, 0);
        total++;
        if (excl_err !== 1'b0) begin
            bad++;
            $display("FAIL exclusivity: shift/transfer overlap or dir without transfer seen=%b want 0", excl_err);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
